// File: rtl/tone_sequencer_if.sv
// tone_sequencer_if
//   Groups the signals between the game FSM (master) and tone_sequencer
//   (slave).
//   master drives: ticks_per_milli, tone_in, mel_start, mel_sel, mel_abort
//   slave drives : freq, mel_busy, mel_done, mel_note
interface tone_sequencer_if;
    logic [15:0] ticks_per_milli;  // clock cycles per millisecond, 0 acts as 1
    logic [9:0]  tone_in;          // direct tone request in Hz, 0 = silence
    logic        mel_start;        // one-cycle pulse: start melody mel_sel
    logic [1:0]  mel_sel;          // 0 success, 1 game over, 2 startup, 3 reserved
    logic        mel_abort;        // one-cycle pulse: stop the melody now
    logic [9:0]  freq;             // registered frequency for the tone generator
    logic        mel_busy;         // a melody owns freq
    logic        mel_done;         // one-cycle pulse on normal melody completion
    logic [2:0]  mel_note;         // current note index, 0 when idle

    modport master (
        output ticks_per_milli, tone_in, mel_start, mel_sel, mel_abort,
        input  freq, mel_busy, mel_done, mel_note
    );

    modport slave (
        input  ticks_per_milli, tone_in, mel_start, mel_sel, mel_abort,
        output freq, mel_busy, mel_done, mel_note
    );
endinterface

// File: rtl/tone_sequencer.sv
// tone_sequencer
//   Chooses, every cycle, the frequency sent to the single tone generator:
//   either the direct tone request or a note from one of three built-in
//   melodies (success, game over, startup) stored in a small note ROM with
//   per-note millisecond durations.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - tone_sequencer_if.slave (tone request, melody handshake, freq out)
module tone_sequencer (
    input  logic             clk,
    input  logic             rst,
    tone_sequencer_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        NOTE = 1'b1
    } state_t;

    typedef struct packed {
        logic [9:0] freq;    // Hz, 0 = rest
        logic [9:0] dur_ms;  // note length in milliseconds
        logic       trem;    // sweep the pitch around freq
        logic       last;    // final note of its melody
    } rom_entry_t;

    // Melody start addresses inside the note ROM.
    localparam logic [3:0] ADDR_SUCCESS  = 4'd0;
    localparam logic [3:0] ADDR_GAMEOVER = 4'd7;
    localparam logic [3:0] ADDR_STARTUP  = 4'd11;

    function automatic rom_entry_t rom_read(input logic [3:0] addr);
        rom_entry_t e;
        unique case (addr)
            // success
            4'd0:    e = '{freq: 10'd330, dur_ms: 10'd150,  trem: 1'b0, last: 1'b0};
            4'd1:    e = '{freq: 10'd392, dur_ms: 10'd150,  trem: 1'b0, last: 1'b0};
            4'd2:    e = '{freq: 10'd659, dur_ms: 10'd150,  trem: 1'b0, last: 1'b0};
            4'd3:    e = '{freq: 10'd523, dur_ms: 10'd150,  trem: 1'b0, last: 1'b0};
            4'd4:    e = '{freq: 10'd587, dur_ms: 10'd150,  trem: 1'b0, last: 1'b0};
            4'd5:    e = '{freq: 10'd784, dur_ms: 10'd150,  trem: 1'b0, last: 1'b0};
            4'd6:    e = '{freq: 10'd0,   dur_ms: 10'd150,  trem: 1'b0, last: 1'b1};
            // game over
            4'd7:    e = '{freq: 10'd622, dur_ms: 10'd300,  trem: 1'b0, last: 1'b0};
            4'd8:    e = '{freq: 10'd587, dur_ms: 10'd300,  trem: 1'b0, last: 1'b0};
            4'd9:    e = '{freq: 10'd554, dur_ms: 10'd300,  trem: 1'b0, last: 1'b0};
            4'd10:   e = '{freq: 10'd523, dur_ms: 10'd1000, trem: 1'b1, last: 1'b1};
            // startup
            4'd11:   e = '{freq: 10'd196, dur_ms: 10'd100,  trem: 1'b0, last: 1'b0};
            4'd12:   e = '{freq: 10'd262, dur_ms: 10'd100,  trem: 1'b0, last: 1'b0};
            4'd13:   e = '{freq: 10'd330, dur_ms: 10'd100,  trem: 1'b0, last: 1'b0};
            4'd14:   e = '{freq: 10'd784, dur_ms: 10'd200,  trem: 1'b0, last: 1'b1};
            // Unused slot: a silent one-millisecond last note, so a stray
            // address terminates cleanly instead of running forever.
            default: e = '{freq: 10'd0,   dur_ms: 10'd1,    trem: 1'b0, last: 1'b1};
        endcase
        return e;
    endfunction

    function automatic logic [3:0] mel_base(input logic [1:0] sel);
        logic [3:0] a;
        unique case (sel)
            2'd0:    a = ADDR_SUCCESS;
            2'd1:    a = ADDR_GAMEOVER;
            default: a = ADDR_STARTUP;
        endcase
        return a;
    endfunction

    // Tremble sweeps base-16 .. base+15, one step per millisecond.
    function automatic logic [9:0] note_freq(input rom_entry_t e, input logic [4:0] ms_lo);
        logic [9:0] f;
        if (e.trem) begin
            f = e.freq - 10'd16 + {5'd0, ms_lo};
        end else begin
            f = e.freq;
        end
        return f;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  addr_q, addr_d;    // absolute ROM address of the current note
    logic [2:0]  note_q, note_d;    // note index within the melody
    logic [15:0] tick_q, tick_d;
    logic [9:0]  ms_q, ms_d;
    logic [9:0]  freq_q, freq_d;
    logic        done_q, done_d;

    rom_entry_t  cur;
    logic [15:0] tpm_eff;
    logic        tick_end;
    logic        start_ok;
    logic [9:0]  ms_inc;
    logic        load_note;
    logic [3:0]  load_addr;
    rom_entry_t  load_entry;

    assign cur      = rom_read(addr_q);
    assign tpm_eff  = (bus.ticks_per_milli == 16'd0) ? 16'd1 : bus.ticks_per_milli;
    // Equality only: if tpm shrinks below the running count, the counter
    // runs on and wraps through 0xFFFF before it can match again.
    assign tick_end = (tick_q == tpm_eff - 16'd1);
    // Abort beats a same-edge start; selector 3 is reserved and ignored.
    assign start_ok = bus.mel_start && (bus.mel_sel != 2'd3) && !bus.mel_abort;
    assign ms_inc   = ms_q + 10'd1;
    assign load_entry = rom_read(load_addr);

    // NOTE: every signal assigned in this block gets a default first, so no
    //       path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        note_d    = note_q;
        tick_d    = tick_q;
        ms_d      = ms_q;
        freq_d    = freq_q;
        done_d    = 1'b0;
        load_note = 1'b0;
        load_addr = addr_q;

        unique case (state_q)
            IDLE: begin
                freq_d = bus.tone_in;
                if (start_ok) begin
                    state_d   = NOTE;
                    note_d    = 3'd0;
                    load_note = 1'b1;
                    load_addr = mel_base(bus.mel_sel);
                end
            end

            NOTE: begin
                if (bus.mel_abort) begin
                    state_d = IDLE;
                    freq_d  = bus.tone_in;
                    note_d  = 3'd0;
                    addr_d  = 4'd0;
                    tick_d  = 16'd0;
                    ms_d    = 10'd0;
                end else if (start_ok) begin
                    // Retrigger: restart from note 0, no done for the old melody.
                    note_d    = 3'd0;
                    load_note = 1'b1;
                    load_addr = mel_base(bus.mel_sel);
                end else if (tick_end) begin
                    tick_d = 16'd0;
                    if (ms_q == cur.dur_ms - 10'd1) begin
                        if (cur.last) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            freq_d  = bus.tone_in;
                            note_d  = 3'd0;
                            addr_d  = 4'd0;
                            ms_d    = 10'd0;
                        end else begin
                            note_d    = note_q + 3'd1;
                            load_note = 1'b1;
                            load_addr = addr_q + 4'd1;
                        end
                    end else begin
                        ms_d   = ms_inc;
                        freq_d = note_freq(cur, ms_inc[4:0]);
                    end
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_note) begin
            addr_d = load_addr;
            tick_d = 16'd0;
            ms_d   = 10'd0;
            freq_d = note_freq(load_entry, 5'd0);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    //       samples the values from before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 4'd0;
            note_q  <= 3'd0;
            tick_q  <= 16'd0;
            ms_q    <= 10'd0;
            freq_q  <= 10'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            tick_q  <= tick_d;
            ms_q    <= ms_d;
            freq_q  <= freq_d;
            done_q  <= done_d;
        end
    end

    assign bus.freq     = freq_q;
    assign bus.mel_busy = (state_q == NOTE);
    assign bus.mel_done = done_q;
    assign bus.mel_note = note_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer
//   Directed self-checking bench for tone_sequencer. Inputs are driven 1 time
//   unit after the rising edge; outputs are sampled at the same point.
module tb_tone_sequencer;

    logic clk = 1'b0;
    logic rst;

    tone_sequencer_if bus_if ();

    tone_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_passed = 0;
    int done_cnt = 0;

    // Count mel_done pulses mid-cycle, away from the clock edge.
    always @(negedge clk) begin
        if (bus_if.mel_done) done_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [1:0] sel);
        bus_if.mel_sel   = sel;
        bus_if.mel_start = 1'b1;
        step(1);
        bus_if.mel_start = 1'b0;
    endtask

    task automatic pulse_abort();
        bus_if.mel_abort = 1'b1;
        step(1);
        bus_if.mel_abort = 1'b0;
    endtask

    int succ_f [7] = '{330, 392, 659, 523, 587, 784, 0};
    int go_f   [3] = '{622, 587, 554};
    int dc0;

    initial begin
        rst                    = 1'b1;
        bus_if.ticks_per_milli = 16'd1;
        bus_if.tone_in         = 10'd262;
        bus_if.mel_start       = 1'b0;
        bus_if.mel_sel         = 2'd0;
        bus_if.mel_abort       = 1'b0;

        // ---------------- reset and direct path ----------------
        #1;
        check("rst_freq", bus_if.freq, 0);
        check("rst_busy", bus_if.mel_busy, 0);
        check("rst_note", bus_if.mel_note, 0);
        check("rst_done", bus_if.mel_done, 0);
        step(2);
        check("rst_hold_freq", bus_if.freq, 0);
        rst = 1'b0;
        step(1);
        check("direct_freq", bus_if.freq, 262);
        check("direct_busy", bus_if.mel_busy, 0);
        bus_if.tone_in = 10'd300;
        step(1);
        check("direct_follow", bus_if.freq, 300);

        // ---------------- success melody, tpm=1 ----------------
        bus_if.tone_in = 10'd440;
        pulse_start(2'd0);
        check("succ_busy", bus_if.mel_busy, 1);
        bus_if.tone_in = 10'd999;   // ignored while busy
        for (int i = 0; i < 7; i++) begin
            check($sformatf("succ_first%0d", i), bus_if.freq, succ_f[i]);
            check($sformatf("succ_note%0d", i), bus_if.mel_note, i);
            step(149);
            check($sformatf("succ_last%0d", i), bus_if.freq, succ_f[i]);
            check($sformatf("succ_nodone%0d", i), bus_if.mel_done, 0);
            if (i == 3) bus_if.tone_in = 10'd440;
            step(1);
        end
        check("succ_done", bus_if.mel_done, 1);
        check("succ_ret_freq", bus_if.freq, 440);
        check("succ_ret_busy", bus_if.mel_busy, 0);
        check("succ_ret_note", bus_if.mel_note, 0);
        step(1);
        check("succ_done_pulse", bus_if.mel_done, 0);

        // ---------------- game over melody, tpm=2 ----------------
        bus_if.tone_in         = 10'd100;
        bus_if.ticks_per_milli = 16'd2;
        pulse_start(2'd1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("go_first%0d", i), bus_if.freq, go_f[i]);
            step(599);
            check($sformatf("go_last%0d", i), bus_if.freq, go_f[i]);
            step(1);
        end
        check("trem_start", bus_if.freq, 507);
        check("trem_note", bus_if.mel_note, 3);
        step(1);
        check("trem_hold", bus_if.freq, 507);
        step(1);
        check("trem_step", bus_if.freq, 508);
        step(60);
        check("trem_top", bus_if.freq, 538);
        step(2);
        check("trem_wrap", bus_if.freq, 507);
        step(1935);
        check("trem_end", bus_if.freq, 514);
        check("go_nodone", bus_if.mel_done, 0);
        step(1);
        check("go_done", bus_if.mel_done, 1);
        check("go_ret_freq", bus_if.freq, 100);

        // ---------------- abort during startup, tpm=1 ----------------
        bus_if.tone_in         = 10'd55;
        bus_if.ticks_per_milli = 16'd1;
        pulse_start(2'd2);
        check("start_first", bus_if.freq, 196);
        step(249);
        check("start_note2", bus_if.freq, 330);
        dc0 = done_cnt;
        pulse_abort();
        check("abort_freq", bus_if.freq, 55);
        check("abort_busy", bus_if.mel_busy, 0);
        check("abort_note", bus_if.mel_note, 0);
        check("abort_done", bus_if.mel_done, 0);
        step(300);
        check("abort_no_done", done_cnt, dc0);

        // Same-edge start and abort while idle: start is dropped.
        bus_if.mel_sel   = 2'd0;
        bus_if.mel_start = 1'b1;
        bus_if.mel_abort = 1'b1;
        step(1);
        bus_if.mel_start = 1'b0;
        bus_if.mel_abort = 1'b0;
        check("both_busy", bus_if.mel_busy, 0);
        check("both_freq", bus_if.freq, 55);

        // ---------------- retrigger ----------------
        pulse_start(2'd0);
        step(399);
        check("retrig_before", bus_if.freq, 659);
        dc0 = done_cnt;
        pulse_start(2'd2);
        check("retrig_freq", bus_if.freq, 196);
        check("retrig_note", bus_if.mel_note, 0);
        check("retrig_busy", bus_if.mel_busy, 1);
        step(499);
        check("retrig_lastnote", bus_if.freq, 784);
        check("retrig_nodone", bus_if.mel_done, 0);
        step(1);
        check("retrig_done", bus_if.mel_done, 1);
        check("retrig_ret_freq", bus_if.freq, 55);
        step(5);
        check("retrig_done_count", done_cnt, dc0 + 1);

        // ---------------- tpm=0 acts as 1 ----------------
        bus_if.ticks_per_milli = 16'd0;
        pulse_start(2'd2);
        step(99);
        check("tpm0_note0", bus_if.freq, 196);
        step(1);
        check("tpm0_note1", bus_if.freq, 262);
        pulse_abort();

        // ---------------- reset mid tremble, then reserved selector ----------------
        bus_if.ticks_per_milli = 16'd1;
        bus_if.tone_in         = 10'd77;
        pulse_start(2'd1);
        step(919);
        check("mid_trem", bus_if.freq, 526);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_freq", bus_if.freq, 0);
        check("async_rst_busy", bus_if.mel_busy, 0);
        check("async_rst_note", bus_if.mel_note, 0);
        step(2);
        rst = 1'b0;
        pulse_start(2'd3);
        check("sel3_busy", bus_if.mel_busy, 0);
        check("sel3_freq", bus_if.freq, 77);
        check("sel3_note", bus_if.mel_note, 0);
        step(3);
        check("sel3_still_idle", bus_if.mel_busy, 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
